rotary_decoder: RTL
===================

# rotary_decoder

Front-end for the volume counter: decodes a two-channel quadrature rotary encoder (A/B) and a push switch into the `up`, `down` and `mode` control signals the counter consumes. It is the producer end of that control interface, between the board pins and the counter. Asynchronous pin inputs are synchronised, optionally debounced, and tracked by a quadrature state machine. The block emits one `up` or `down` strobe per complete detent and toggles `mode` on each press.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a filtered input changes. Legal range 1..255. Used only with `ROTARY_DEBOUNCE_EN`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `n_reset`  in  1  reset, asynchronous and active-low.
- `enc_a`  in  1  encoder channel A; asynchronous, rests high.
- `enc_b`  in  1  encoder channel B; asynchronous, rests high.
- `push`  in  1  push switch; asynchronous, active-high.
- `up`  out  1  one-cycle strobe, one clockwise detent completed.
- `down`  out  1  one-cycle strobe, one counter-clockwise detent completed.
- `mode`  out  1  level; toggles on each accepted press.

## Operation
- Synchroniser: two flops per input. Reset values are 1 for A/B and 0 for push.
- Filter (macro enabled):
  - Each filtered bit holds its value until the synchronised input has differed from it for `DEBOUNCE_CYCLES` consecutive edges; it then takes the new value.
  - A glitch shorter than this resets the per-input count to 0.
  - Reset values: filtered A/B = 1, filtered push = 0.
- Quadrature FSM on filtered {A,B}. States: IDLE(11), CW1(01), CW2(00), CW3(10), CCW1(10), CCW2(00), CCW3(01), ERR.
  - IDLE: 01→CW1; 10→CCW1; 00→ERR.
  - CW1: 00→CW2; 11→IDLE, no strobe; 10→ERR.
  - CW2: 10→CW3; 01→CW1; 11→ERR.
  - CW3: 11→IDLE and assert `up`; 00→CW2; 01→ERR.
  - CCW1: 00→CCW2; 11→IDLE, no strobe; 01→ERR.
  - CCW2: 01→CCW3; 10→CCW1; 11→ERR.
  - CCW3: 11→IDLE and assert `down`; 00→CCW2; 10→ERR.
  - ERR: stays in ERR until 11 is seen, then goes to IDLE with no strobe.
  - An unchanged input holds the current state.
- `up` and `down` are registered. They are never high together and each is high for exactly one cycle per detent.
- `mode` toggles on the cycle the filtered push rises. A held press causes no further toggles. Push handling is independent of rotation; a simultaneous strobe and toggle are both honoured.

## Timing
- Reset: `up`=0, `down`=0, `mode`=0, FSM=IDLE, all filter counters 0. Asserting reset mid-detent discards the partial sequence and emits no strobe.
- Without the macro, a pin change sampled at edge k:
  - is in the FSM input after edge k+1;
  - the output reacts at edge k+2; the strobe is high from edge k+2 to edge k+3.
- With the macro: add `DEBOUNCE_CYCLES` edges to the latency above.
- Deassertion of `n_reset` is assumed synchronous to `clk` by the board-level reset logic.

## Configuration
- `ROTARY_DEBOUNCE_EN` defined: per-input debounce filters are instantiated as described above.
- `ROTARY_DEBOUNCE_EN` undefined: filtered values equal the synchroniser outputs, and `DEBOUNCE_CYCLES` is ignored.

## Structure
- Shared package `input_pkg` holds:
  - `quad_state_t`, the FSM enum typedef;
  - `ENC_REST = 2'b11`;
  - the `DEBOUNCE_CYCLES` default constant.
- Sub-module `debounce`:
  - one instance per input (three total), parameterised by cycle count and reset value;
  - contains the synchroniser and the filter;
  - uses a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.

## Test plan
Conditions: 20 ns clock, macro enabled, `DEBOUNCE_CYCLES`=4.
- Reset held for 50 ns with A=B=1 → `up`=`down`=`mode`=0 throughout; all three stay 0 for 200 ns after release.
- Clockwise sequence 11→01→00→10→11, 200 ns per step → exactly one `up` pulse, 20 ns wide, rising 7 edges after the final step; `down` stays 0.
- Counter-clockwise sequence repeated 3 times → exactly 3 `down` pulses; `up` stays 0.
- Partial sequence 11→01→00→01→11, then an invalid jump 11→00→11 → no strobes; a following clockwise detent gives one `up`.
- 40 ns glitch on A while idle → no state change and no strobe. Push held for 1 µs → `mode` goes 0→1 once; a second press → `mode` 1→0.
- `n_reset` pulsed low while the FSM is in CW3 → no `up`; FSM in IDLE after release. Then a clockwise detent concurrent with a push → `up` pulse and `mode` toggle both occur.

Source files
------------

// File: rtl/input_pkg.sv
// -----------------------------------------------------------------------------
// input_pkg
// Shared definitions for the rotary encoder front-end:
//   quad_state_t             quadrature FSM state encoding
//   ENC_REST                 {A,B} value of an encoder sitting on a detent
//   DEBOUNCE_CYCLES_DEFAULT  default filter length (stable cycles)
// -----------------------------------------------------------------------------
package input_pkg;

  typedef enum logic [2:0] {
    Q_IDLE = 3'd0,
    Q_CW1  = 3'd1,
    Q_CW2  = 3'd2,
    Q_CW3  = 3'd3,
    Q_CCW1 = 3'd4,
    Q_CCW2 = 3'd5,
    Q_CCW3 = 3'd6,
    Q_ERR  = 3'd7
  } quad_state_t;

  localparam logic [1:0]  ENC_REST                = 2'b11;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/debounce.sv
// -----------------------------------------------------------------------------
// debounce
// Two-flop synchroniser followed by an optional stability filter for one
// asynchronous pin.
//   Build macro: ROTARY_DEBOUNCE_EN (filter present when defined, otherwise
//   the output is the synchroniser output).
// Parameters:
//   CYCLES   consecutive differing cycles needed before the output changes
//   RST_VAL  reset value of the synchroniser flops and the filtered output
// Ports:
//   clk      system clock
//   n_reset  asynchronous active-low reset
//   pin_i    raw asynchronous pin
//   filt_o   synchronised (and filtered) level
// -----------------------------------------------------------------------------
module debounce #(
  parameter int unsigned CYCLES  = 4,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_reset,
  input  logic pin_i,
  output logic filt_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) sync_q <= {2{RST_VAL}};
    else          sync_q <= {sync_q[0], pin_i};
  end

`ifdef ROTARY_DEBOUNCE_EN
  localparam int CNT_W = $clog2(CYCLES + 1);

  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter tracks how long the synchronised level has disagreed with
  // the filtered one. Any agreement (a glitch ending) clears it.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_W'(CYCLES - 1)) filt_d = sync_q[1];
      else                             cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      filt_q <= RST_VAL;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;
`else
  // Filter compiled out: the cycle count has no effect in this build.
  logic unused_cycles;
  assign unused_cycles = ^CYCLES;
  assign filt_o        = sync_q[1];
`endif

endmodule

// File: rtl/rotary_decoder.sv
// -----------------------------------------------------------------------------
// rotary_decoder
// Quadrature rotary encoder + push switch front-end for the volume counter.
// Pins are synchronised (and debounced when ROTARY_DEBOUNCE_EN is defined),
// a quadrature FSM emits one up/down strobe per full detent, and each new
// press toggles mode.
// Build macro: ROTARY_DEBOUNCE_EN (enables per-input debounce filters).
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles before a filtered input changes (1..255)
// Ports:
//   clk      system clock, rising edge
//   n_reset  asynchronous active-low reset
//   enc_a    encoder channel A (async, rests high)
//   enc_b    encoder channel B (async, rests high)
//   push     push switch (async, active high)
//   up       one-cycle strobe per clockwise detent
//   down     one-cycle strobe per counter-clockwise detent
//   mode     level, toggles on each accepted press
// -----------------------------------------------------------------------------
module rotary_decoder
  import input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic n_reset,
  input  logic enc_a,
  input  logic enc_b,
  input  logic push,
  output logic up,
  output logic down,
  output logic mode
);

  logic a_f, b_f, push_f;

  debounce #(.CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_deb_a (
    .clk(clk), .n_reset(n_reset), .pin_i(enc_a), .filt_o(a_f)
  );
  debounce #(.CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_deb_b (
    .clk(clk), .n_reset(n_reset), .pin_i(enc_b), .filt_o(b_f)
  );
  debounce #(.CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_deb_push (
    .clk(clk), .n_reset(n_reset), .pin_i(push), .filt_o(push_f)
  );

  logic [1:0]  ab;
  quad_state_t state_q, state_d;
  logic        up_q, up_d, down_q, down_d;
  logic        mode_q, mode_d, push_prev_q;

  assign ab = {a_f, b_f};

  // Quadrature tracker. Inputs not listed for a state are the "unchanged"
  // value and hold. Strobes fire only when the last quarter step of a
  // detent returns to rest; backing out to rest early emits nothing.
  always_comb begin
    state_d = state_q;
    up_d    = 1'b0;
    down_d  = 1'b0;
    case (state_q)
      Q_IDLE: begin
        case (ab)
          2'b01:   state_d = Q_CW1;
          2'b10:   state_d = Q_CCW1;
          2'b00:   state_d = Q_ERR;
          default: state_d = state_q;
        endcase
      end
      Q_CW1: begin
        case (ab)
          2'b00:   state_d = Q_CW2;
          2'b11:   state_d = Q_IDLE;
          2'b10:   state_d = Q_ERR;
          default: state_d = state_q;
        endcase
      end
      Q_CW2: begin
        case (ab)
          2'b10:   state_d = Q_CW3;
          2'b01:   state_d = Q_CW1;
          2'b11:   state_d = Q_ERR;
          default: state_d = state_q;
        endcase
      end
      Q_CW3: begin
        case (ab)
          2'b11: begin
            state_d = Q_IDLE;
            up_d    = 1'b1;
          end
          2'b00:   state_d = Q_CW2;
          2'b01:   state_d = Q_ERR;
          default: state_d = state_q;
        endcase
      end
      Q_CCW1: begin
        case (ab)
          2'b00:   state_d = Q_CCW2;
          2'b11:   state_d = Q_IDLE;
          2'b01:   state_d = Q_ERR;
          default: state_d = state_q;
        endcase
      end
      Q_CCW2: begin
        case (ab)
          2'b01:   state_d = Q_CCW3;
          2'b10:   state_d = Q_CCW1;
          2'b11:   state_d = Q_ERR;
          default: state_d = state_q;
        endcase
      end
      Q_CCW3: begin
        case (ab)
          2'b11: begin
            state_d = Q_IDLE;
            down_d  = 1'b1;
          end
          2'b00:   state_d = Q_CCW2;
          2'b10:   state_d = Q_ERR;
          default: state_d = state_q;
        endcase
      end
      Q_ERR: begin
        if (ab == ENC_REST) state_d = Q_IDLE;
      end
      default: state_d = Q_ERR;
    endcase
  end

  // Toggle only on the rising edge of the filtered press.
  assign mode_d = mode_q ^ (push_f & ~push_prev_q);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= Q_IDLE;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      mode_q      <= 1'b0;
      push_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      up_q        <= up_d;
      down_q      <= down_d;
      mode_q      <= mode_d;
      push_prev_q <= push_f;
    end
  end

  assign up   = up_q;
  assign down = down_q;
  assign mode = mode_q;

endmodule
